sobel_frame_sched: RTL and testbench



---
 rtl/sobel_frame_sched_if.sv | 27 ++
 rtl/sobel_frame_sched.sv | 201 ++++++++++++++++++++
 tb/tb_sobel_frame_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_sched_if.sv
// Bus bundle between the Sobel frame scheduler and its surroundings:
// single-port BRAM read channel, kernel window link and output pixel stream.
interface sobel_frame_sched_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [63:0]       win_data;
    logic [7:0]        kern_result;
    logic [7:0]        pix_out;
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] pix_index;

    // Scheduler side
    modport master (
        output mem_en, mem_addr, win_data, pix_out, pix_valid, pix_index,
        input  mem_rdata, kern_result, pix_ready
    );

    // BRAM / kernel / consumer side
    modport slave (
        input  mem_en, mem_addr, win_data, pix_out, pix_valid, pix_index,
        output mem_rdata, kern_result, pix_ready
    );
endinterface

// File: rtl/sobel_frame_sched.sv
// Sobel frame scheduler: walks a WIDTH x HEIGHT frame in raster order,
// serialises the eight neighbour reads through one BRAM port, hands the
// assembled window to the combinational kernel and streams results out.
// Border pixels are emitted as 0 without touching the BRAM.
// Optional build macro: SOBEL_SCHED_STALL_CNT_EN adds the stall_cycles
// output counting cycles where a pixel is offered but not accepted.
module sobel_frame_sched #(
    parameter int unsigned WIDTH    = 100,
    parameter int unsigned HEIGHT   = 100,
    parameter int unsigned BASE     = 1078,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                header_done,
    input  logic                start,
    sobel_frame_sched_if.master bus,
    output logic                busy,
    output logic                done
`ifdef SOBEL_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int unsigned AW1   = ADDR_W + 1;
    localparam int unsigned NPIX  = WIDTH * HEIGHT;
    localparam int unsigned COL_W = $clog2(WIDTH + 1);
    localparam int unsigned ROW_W = $clog2(HEIGHT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        FETCH,
        WAIT,
        LOAD,
        EMIT,
        FIN
    } state_t;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [2:0]         req_k;
    logic [1:0]         wait_cnt;
    logic               is_border;
    logic [READ_LAT-1:0] tag_vld;
    logic [2:0]         tag_k [READ_LAT];
    logic               border;

    // Neighbour address for slot k; the extra bit keeps the signed offsets exact
    function automatic logic [ADDR_W-1:0] nb_addr(input logic [ADDR_W-1:0] idx,
                                                  input logic [2:0]        k);
        logic [AW1-1:0] ctr;
        logic [AW1-1:0] w;
        logic [AW1-1:0] sum;
        ctr = AW1'(BASE) + AW1'(idx);
        w   = AW1'(WIDTH);
        case (k)
            3'd0:    sum = ctr - w - AW1'(1);
            3'd1:    sum = ctr - w;
            3'd2:    sum = ctr - w + AW1'(1);
            3'd3:    sum = ctr - AW1'(1);
            3'd4:    sum = ctr + AW1'(1);
            3'd5:    sum = ctr + w - AW1'(1);
            3'd6:    sum = ctr + w;
            default: sum = ctr + w + AW1'(1);
        endcase
        return ADDR_W'(sum);
    endfunction

    // Current pixel lies on the frame edge
    assign border = (row == '0) || (row == ROW_W'(HEIGHT - 1)) ||
                    (col == '0) || (col == COL_W'(WIDTH - 1));

    // Scheduler FSM, read tag pipeline and window capture
    always_ff @(posedge clk) begin
        if (rst || !header_done) begin
            state         <= IDLE;
            bus.mem_en    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.win_data  <= '0;
            bus.pix_out   <= '0;
            bus.pix_valid <= 1'b0;
            bus.pix_index <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            col           <= '0;
            row           <= '0;
            req_k         <= '0;
            wait_cnt      <= '0;
            is_border     <= 1'b0;
            tag_vld       <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) tag_k[i] <= '0;
`ifdef SOBEL_SCHED_STALL_CNT_EN
            stall_cycles  <= '0;
`endif
        end else begin
            done <= 1'b0;

            // Each issued read carries its window slot until the data returns
            tag_vld[0] <= bus.mem_en;
            tag_k[0]   <= req_k;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_k[i]   <= tag_k[i-1];
            end
            if (tag_vld[READ_LAT-1]) begin
                bus.win_data[{tag_k[READ_LAT-1], 3'b000} +: 8] <= bus.mem_rdata;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= CLASSIFY;
                        bus.pix_index <= '0;
                        col           <= '0;
                        row           <= '0;
                        busy          <= 1'b1;
`ifdef SOBEL_SCHED_STALL_CNT_EN
                        stall_cycles  <= '0;
`endif
                    end
                end

                CLASSIFY: begin
                    if (border) begin
                        // Border pixels use the LOAD slot to present a forced 0
                        is_border <= 1'b1;
                        state     <= LOAD;
                    end else begin
                        is_border    <= 1'b0;
                        state        <= FETCH;
                        req_k        <= '0;
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= nb_addr(bus.pix_index, 3'd0);
                    end
                end

                FETCH: begin
                    if (req_k == 3'd7) begin
                        bus.mem_en <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= WAIT;
                    end else begin
                        req_k        <= req_k + 3'd1;
                        bus.mem_addr <= nb_addr(bus.pix_index, req_k + 3'd1);
                    end
                end

                WAIT: begin
                    if (wait_cnt == 2'(READ_LAT - 1)) begin
                        state <= LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end

                LOAD: begin
                    bus.pix_out   <= is_border ? 8'd0 : bus.kern_result;
                    bus.pix_valid <= 1'b1;
                    state         <= EMIT;
                end

                EMIT: begin
                    if (bus.pix_ready) begin
                        bus.pix_valid <= 1'b0;
                        if (bus.pix_index == ADDR_W'(NPIX - 1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end else begin
                            bus.pix_index <= bus.pix_index + ADDR_W'(1);
                            if (col == COL_W'(WIDTH - 1)) begin
                                col <= '0;
                                row <= row + ROW_W'(1);
                            end else begin
                                col <= col + COL_W'(1);
                            end
                            state <= CLASSIFY;
                        end
                    end else begin
`ifdef SOBEL_SCHED_STALL_CNT_EN
                        if (stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
`endif
                    end
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_frame_sched.sv
// Directed bench for sobel_frame_sched: two 4x4 instances (READ_LAT 1 and 3),
// a BRAM model returning address[7:0] and a kernel model returning p1.
`timescale 1ns/1ps
module tb_sobel_frame_sched;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 4;
    localparam int unsigned BASE = 1078;
    localparam int unsigned AW   = 14;

    logic clk = 1'b0;
    logic rst;
    logic header_done_s;
    logic start_s;
    logic pix_ready_s;
    logic sel;

    always #5 clk = ~clk;

    sobel_frame_sched_if #(.ADDR_W(AW)) bus_a ();
    sobel_frame_sched_if #(.ADDR_W(AW)) bus_b ();

    logic start_a, start_b, busy_a, busy_b, done_a, done_b;
    assign start_a = start_s & ~sel;
    assign start_b = start_s & sel;
    assign bus_a.pix_ready   = pix_ready_s & ~sel;
    assign bus_b.pix_ready   = pix_ready_s & sel;
    assign bus_a.kern_result = bus_a.win_data[15:8];
    assign bus_b.kern_result = bus_b.win_data[15:8];

`ifdef SOBEL_SCHED_STALL_CNT_EN
    logic [31:0] stall_a, stall_b, o_stall;
    assign o_stall = sel ? stall_b : stall_a;
`endif

    sobel_frame_sched #(.WIDTH(W), .HEIGHT(H), .BASE(BASE), .ADDR_W(AW), .READ_LAT(1)) u_a (
        .clk(clk), .rst(rst), .header_done(header_done_s), .start(start_a),
        .bus(bus_a.master), .busy(busy_a), .done(done_a)
`ifdef SOBEL_SCHED_STALL_CNT_EN
        , .stall_cycles(stall_a)
`endif
    );

    sobel_frame_sched #(.WIDTH(W), .HEIGHT(H), .BASE(BASE), .ADDR_W(AW), .READ_LAT(3)) u_b (
        .clk(clk), .rst(rst), .header_done(header_done_s), .start(start_b),
        .bus(bus_b.master), .busy(busy_b), .done(done_b)
`ifdef SOBEL_SCHED_STALL_CNT_EN
        , .stall_cycles(stall_b)
`endif
    );

    // BRAM models: data = address[7:0]; 8'hEE whenever no read is returning
    logic [8:0] pa, pb0, pb1, pb2;
    always @(posedge clk) begin
        pa  <= {bus_a.mem_en, bus_a.mem_addr[7:0]};
        pb0 <= {bus_b.mem_en, bus_b.mem_addr[7:0]};
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign bus_a.mem_rdata = pa[8]  ? pa[7:0]  : 8'hEE;
    assign bus_b.mem_rdata = pb2[8] ? pb2[7:0] : 8'hEE;

    // Observed signals of the selected instance
    logic          o_mem_en, o_valid, o_busy, o_done;
    logic [AW-1:0] o_mem_addr, o_index;
    logic [63:0]   o_win;
    logic [7:0]    o_pix;
    assign o_mem_en   = sel ? bus_b.mem_en    : bus_a.mem_en;
    assign o_mem_addr = sel ? bus_b.mem_addr  : bus_a.mem_addr;
    assign o_win      = sel ? bus_b.win_data  : bus_a.win_data;
    assign o_pix      = sel ? bus_b.pix_out   : bus_a.pix_out;
    assign o_valid    = sel ? bus_b.pix_valid : bus_a.pix_valid;
    assign o_index    = sel ? bus_b.pix_index : bus_a.pix_index;
    assign o_busy     = sel ? busy_b : busy_a;
    assign o_done     = sel ? done_b : done_a;

    int done_cnt = 0;
    always @(posedge clk) if (o_done) done_cnt <= done_cnt + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int unsigned   stall;     // cycles pix_ready is held low once the pixel is offered
        logic [AW-1:0] idx;
        bit            interior;
        logic [7:0]    pix;
        logic [63:0]   win;
    } vec_t;

    vec_t          vec [16];
    logic [AW-1:0] exp5 [8];

    // One full frame on the selected instance, checked against the vector table
    task automatic run_frame(input int rl);
        int            gap;
        int            reads;
        int            exp_gap;
        int            d0;
        int unsigned   exp_stall;
        logic [AW-1:0] addrs [8];
        exp_stall = 0;
        for (int i = 0; i < 16; i++) exp_stall += vec[i].stall;
        d0 = done_cnt;
        chk("busy_before_start", 64'(o_busy), 64'd0);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("busy_after_start", 64'(o_busy), 64'd1);
        for (int i = 0; i < 16; i++) begin
            pix_ready_s = (vec[i].stall == 0);
            gap   = 0;
            reads = 0;
            for (int k = 0; k < 8; k++) addrs[k] = '0;
            while (!o_valid && gap < 40) begin
                if (o_mem_en) begin
                    if (reads < 8) addrs[reads] = o_mem_addr;
                    reads++;
                end
                start_s = (i == 5 && gap == 3);
                @(negedge clk);
                gap++;
            end
            start_s = 1'b0;
            exp_gap = vec[i].interior ? 10 + rl : 2;
            chk($sformatf("latency[%0d]", i), 64'(gap), 64'(exp_gap));
            chk($sformatf("reads[%0d]", i), 64'(reads), vec[i].interior ? 64'd8 : 64'd0);
            chk($sformatf("index[%0d]", i), 64'(o_index), 64'(vec[i].idx));
            chk($sformatf("pix[%0d]", i), 64'(o_pix), 64'(vec[i].pix));
            if (vec[i].interior) chk($sformatf("win[%0d]", i), o_win, vec[i].win);
            if (i == 5) begin
                for (int k = 0; k < 8; k++)
                    chk($sformatf("addr5[%0d]", k), 64'(addrs[k]), 64'(exp5[k]));
            end
            for (int s = 0; s < int'(vec[i].stall); s++) begin
                @(negedge clk);
                chk($sformatf("stall_hold[%0d]", i), {o_valid, o_mem_en, o_index, o_pix},
                    {1'b1, 1'b0, vec[i].idx, vec[i].pix});
            end
            pix_ready_s = 1'b1;
            @(negedge clk);
        end
        chk("fin_state", {o_done, o_busy, o_valid}, 3'b100);
        @(negedge clk);
        chk("idle_after_fin", {o_done, o_busy, o_valid}, 3'b000);
        @(negedge clk);
        chk("done_once", 64'(done_cnt - d0), 64'd1);
`ifdef SOBEL_SCHED_STALL_CNT_EN
        chk("stall_cycles", 64'(o_stall), 64'(exp_stall));
`endif
    endtask

    initial begin
        int d0;
        int cnt;
        int en_seen;

        // Vector table: border pixels give 0, interior pixels give p1 = (BASE+idx-W)[7:0]
        for (int i = 0; i < 16; i++) vec[i] = '{0, AW'(i), 1'b0, 8'h00, 64'h0};
        vec[5]  = '{0, 14'd5,  1'b1, 8'h37, 64'h403F3E3C3A383736};
        vec[6]  = '{7, 14'd6,  1'b1, 8'h38, 64'h41403F3D3B393837};
        vec[9]  = '{0, 14'd9,  1'b1, 8'h3B, 64'h444342403E3C3B3A};
        vec[10] = '{0, 14'd10, 1'b1, 8'h3C, 64'h454443413F3D3C3B};
        vec[13] = '{3, 14'd13, 1'b0, 8'h00, 64'h0};
        exp5[0] = 14'd1078; exp5[1] = 14'd1079; exp5[2] = 14'd1080; exp5[3] = 14'd1082;
        exp5[4] = 14'd1084; exp5[5] = 14'd1086; exp5[6] = 14'd1087; exp5[7] = 14'd1088;

        sel           = 1'b0;
        rst           = 1'b1;
        header_done_s = 1'b1;
        start_s       = 1'b0;
        pix_ready_s   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl_a", {bus_a.mem_en, bus_a.pix_valid, busy_a, done_a,
                          bus_a.mem_addr, bus_a.pix_index, bus_a.pix_out}, 64'd0);
        chk("rst_win_a", bus_a.win_data, 64'd0);
        chk("rst_ctl_b", {bus_b.mem_en, bus_b.pix_valid, busy_b, done_b,
                          bus_b.mem_addr, bus_b.pix_index, bus_b.pix_out}, 64'd0);
        chk("rst_win_b", bus_b.win_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // READ_LAT=1 frame
        run_frame(1);

        // Abort in the middle of the first interior fetch
        pix_ready_s = 1'b1;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cnt = 0;
        while (!o_mem_en && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort_reached_fetch", 64'(o_mem_en), 64'd1);
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        header_done_s = 1'b0;
        @(negedge clk);
        chk("abort_ctl", {o_mem_en, o_busy, o_valid, o_index}, 64'd0);
        chk("abort_win", o_win, 64'd0);
        header_done_s = 1'b1;
        en_seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (o_mem_en || o_busy || o_valid) en_seen++;
        end
        chk("abort_stays_idle", 64'(en_seen), 64'd0);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // Restart after abort runs from index 0
        run_frame(1);

        // READ_LAT=3 frame on the second instance
        sel = 1'b1;
        @(negedge clk);
        run_frame(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
